// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 1-bit line mux.
// Grants one requester at a time, caps contended hold time and inserts guard cycles between owners.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD     = 16,
    parameter int GUARD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t          state_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [GW-1:0]   guard_cnt_reg;
    logic [1:0]      last_owner_reg;
    logic [3:0]      gnt_reg;
    logic [1:0]      sel_reg;
    logic            busy_reg;
    logic            preempt_reg;

    logic [1:0]      winner;
    logic            owner_req;
    logic            others_req;
    logic            hold_expired;
    logic            guard_done;

    // Scan starts just after the last owner so it ends up lowest priority.
    always_comb begin
        logic found;
        logic [1:0] cand;
        winner = last_owner_reg;
        found  = 1'b0;
        cand   = last_owner_reg;
        for (int i = 1; i <= 4; i++) begin
            cand = last_owner_reg + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_req    = |(req & gnt_reg);
    assign others_req   = |(req & ~gnt_reg);
    assign hold_expired = (hold_cnt_reg == HW'(MAX_HOLD - 1));
    assign guard_done   = (guard_cnt_reg == GW'(GUARD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_cnt_reg   <= '0;
            guard_cnt_reg  <= '0;
            last_owner_reg <= 2'd3;
            gnt_reg        <= 4'b0000;
            sel_reg        <= 2'd0;
            busy_reg       <= 1'b0;
            preempt_reg    <= 1'b0;
        end else begin
            preempt_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        state_reg      <= ST_GRANT;
                        gnt_reg        <= 4'b0001 << winner;
                        sel_reg        <= winner;
                        last_owner_reg <= winner;
                        hold_cnt_reg   <= '0;
                        busy_reg       <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // Release wins over expiry, so a simultaneous drop never flags preempt.
                    if (!owner_req) begin
                        state_reg     <= ST_GUARD;
                        gnt_reg       <= 4'b0000;
                        guard_cnt_reg <= '0;
                    end else if (hold_expired && others_req) begin
                        state_reg     <= ST_GUARD;
                        gnt_reg       <= 4'b0000;
                        guard_cnt_reg <= '0;
                        preempt_reg   <= 1'b1;
                    end else if (hold_expired) begin
                        hold_cnt_reg <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (guard_done) begin
                        state_reg     <= ST_IDLE;
                        guard_cnt_reg <= '0;
                        busy_reg      <= 1'b0;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= 4'b0000;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign sel     = sel_reg;
    assign busy    = busy_reg;
    assign preempt = preempt_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random request traffic
// checked every cycle against an owner/countdown reference model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD     = 16;
    localparam int GUARD_CYCLES = 1;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    // Reference model: who owns the line, how long, and how much guard is left.
    int m_owner      = -1;
    int m_held       = 0;
    int m_guard_left = 0;
    int m_last       = 3;
    int m_sel        = 0;
    int m_pre        = 0;

    mux4_rr_arbiter #(
        .MAX_HOLD     (MAX_HOLD),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp_v);
        end
    endtask

    task automatic model_update(input logic r, input logic [3:0] rq);
        logic [3:0] own_mask;
        m_pre = 0;
        if (r) begin
            m_owner = -1; m_held = 0; m_guard_left = 0; m_last = 3; m_sel = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            own_mask = 4'(1 << m_owner);
            if (!rq[m_owner]) begin
                m_owner = -1;
                m_guard_left = GUARD_CYCLES;
            end else if ((m_held % MAX_HOLD) == 0 && (rq & ~own_mask) != 4'b0000) begin
                m_owner = -1;
                m_guard_left = GUARD_CYCLES;
                m_pre = 1;
            end
        end else if (m_guard_left > 0) begin
            m_guard_left--;
        end else if (rq != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (rq[c]) begin
                    m_owner = c; m_sel = c; m_last = c; m_held = 0;
                    break;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic r, input logic [3:0] rq);
        logic [3:0] e_gnt;
        rst = r;
        req = rq;
        @(posedge clk);
        model_update(r, rq);
        @(negedge clk);
        step_no++;
        e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_guard_left > 0)));
        chk("preempt", 32'(preempt), 32'(m_pre));
        $display("step %0d rst=%b req=%b gnt=%b sel=%0d busy=%b preempt=%b",
                 step_no, r, rq, gnt, sel, busy, preempt);
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [3:0] rq;
        logic [3:0] prev_gnt;
        int order[$];
        int exp_order[5];
        int cnt_a;
        int cnt_b;
        int seen;

        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);

        // Reset state and a single request / release.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0001);
        chk("s1_gnt", 32'(gnt), 32'h1);
        chk("s1_busy", 32'(busy), 32'h1);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        chk("s1_idle_busy", 32'(busy), 32'h0);

        // All four requesting, each owner lets go after three cycles.
        step(1'b1, 4'b0000);
        order.delete();
        prev_gnt = 4'b0000;
        for (int s = 0; s < 24; s++) begin
            rq = 4'b1111;
            if (m_owner >= 0 && m_held >= 2) rq[m_owner] = 1'b0;
            step(1'b0, rq);
            if (gnt != 4'b0000 && gnt != prev_gnt) order.push_back(idx_of(gnt));
            prev_gnt = gnt;
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("s2_grants", 32'(order.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("s2_order", 32'(order[i]), 32'(exp_order[i]));

        // Contended hold expiry.
        step(1'b1, 4'b0000);
        cnt_a = 0; cnt_b = 0; seen = 0;
        for (int s = 1; s <= 25; s++) begin
            step(1'b0, (s >= 5) ? 4'b0101 : 4'b0001);
            if (gnt == 4'b0001) cnt_a++;
            if (preempt) cnt_b++;
            if (gnt == 4'b0100) seen = 1;
        end
        chk("s3_hold_cycles", 32'(cnt_a), 32'd16);
        chk("s3_preempt_pulses", 32'(cnt_b), 32'd1);
        chk("s3_next_owner", 32'(seen), 32'd1);

        // Uncontended owner keeps the line across hold wraps.
        step(1'b1, 4'b0000);
        cnt_a = 0; cnt_b = 0;
        for (int s = 0; s < 40; s++) begin
            step(1'b0, 4'b0010);
            if (gnt == 4'b0010) cnt_a++;
            if (preempt) cnt_b++;
        end
        chk("s4_continuous", 32'(cnt_a), 32'd40);
        chk("s4_no_preempt", 32'(cnt_b), 32'd0);

        // Reset in the middle of a grant.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1000);
        chk("s5_owner3", 32'(gnt), 32'h8);
        step(1'b1, 4'b1001);
        chk("s5_rst_gnt", 32'(gnt), 32'h0);
        chk("s5_rst_sel", 32'(sel), 32'h0);
        chk("s5_rst_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b1001);
        chk("s5_req0_wins", 32'(gnt), 32'h1);

        // Owner releases exactly when its hold expires with others pending.
        step(1'b1, 4'b0000);
        cnt_b = 0;
        for (int s = 1; s <= 17; s++) begin
            step(1'b0, (s == 17) ? 4'b0010 : 4'b0011);
            if (preempt) cnt_b++;
        end
        chk("s6_gnt", 32'(gnt), 32'h0);
        chk("s6_busy", 32'(busy), 32'h1);
        chk("s6_no_preempt", 32'(cnt_b), 32'd0);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        chk("s6_next_owner", 32'(gnt), 32'h2);

        // Random persistent request traffic with occasional resets.
        rq = 4'b0000;
        for (int s = 0; s < 600; s++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
